// File: rtl/i2c_master_bit_engine.sv
// I2C master bit engine: executes one bus symbol (START/STOP/DATA/ACK/NACK/READ) per accepted go.
// Optional clock stretching is compiled in with the macro I2C_CLOCK_STRETCH_EN.
module i2c_master_bit_engine #(
    parameter int SLOT_CYCLES = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       go,
    input  logic [2:0] command,
    output logic       busy,
    output logic       done,
    output logic       rx_bit,
    output logic       arb_lost,
    output logic       scl_o,
    output logic       sda_o,
    input  logic       scl_i,
    input  logic       sda_i
);

    localparam int PRE_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SLOT_CYCLES - 1);

    typedef enum logic [2:0] {
        CMD_IDLE   = 3'b000,
        CMD_READ   = 3'b001,
        CMD_START  = 3'b010,
        CMD_STOP   = 3'b011,
        CMD_DATA_0 = 3'b100,
        CMD_DATA_1 = 3'b101,
        CMD_ACK    = 3'b110,
        CMD_NACK   = 3'b111
    } cmd_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e           state;
    cmd_e             cmd_q;
    logic [PRE_W-1:0] pre;
    logic [2:0]       slot;

    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   sda_s;
    logic                   freeze;
    logic                   arb_hit;

    // {scl, sda} to register when entering slot 'sl' of command 'cmd'
    function automatic logic [1:0] slot_drive(input cmd_e       cmd,
                                              input logic [2:0] sl,
                                              input logic       scl_cur,
                                              input logic       sda_cur);
        logic       v;
        logic [1:0] drv;
        v   = (cmd == CMD_DATA_1) || (cmd == CMD_NACK);
        drv = {scl_cur, sda_cur};
        case (cmd)
            CMD_START: begin
                case (sl)
                    3'd0:                      drv = (scl_cur & sda_cur) ? 2'b11 : {1'b0, sda_cur};
                    3'd1:                      drv = {scl_cur, 1'b1};
                    3'd2, 3'd3, 3'd4, 3'd5:    drv = 2'b11;
                    default:                   drv = 2'b10;
                endcase
            end
            CMD_STOP: begin
                case (sl)
                    3'd0:                      drv = {1'b0, sda_cur};
                    3'd1, 3'd2, 3'd3:          drv = 2'b00;
                    3'd4, 3'd5:                drv = 2'b10;
                    default:                   drv = 2'b11;
                endcase
            end
            CMD_READ: begin
                if (sl == 3'd0) drv = {1'b0, sda_cur};
                else            drv = {sl[2], 1'b1};
            end
            CMD_IDLE: drv = {scl_cur, sda_cur};
            default: begin
                if (sl == 3'd0) drv = {1'b0, sda_cur};
                else            drv = {sl[2], v};
            end
        endcase
        return drv;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sda_sync <= '1;
        end else begin
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
        end
    end

    assign sda_s = sda_sync[SYNC_STAGES-1];

`ifdef I2C_CLOCK_STRETCH_EN
    logic [SYNC_STAGES-1:0] scl_sync;
    logic                   scl_s;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scl_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
        end
    end

    assign scl_s = scl_sync[SYNC_STAGES-1];

    // A slave holding SCL low after we released it stalls the symbol
    assign freeze = (state == S_RUN) && slot[2] && scl_o && !scl_s;
`else
    logic unused_scl;
    assign unused_scl = scl_i;
    assign freeze     = 1'b0;
`endif

    assign arb_hit = (state == S_RUN) && (cmd_q == CMD_DATA_1) && slot[2]
                     && sda_o && !sda_s && !freeze;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cmd_q    <= CMD_IDLE;
            pre      <= '0;
            slot     <= 3'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rx_bit   <= 1'b0;
            arb_lost <= 1'b0;
            scl_o    <= 1'b1;
            sda_o    <= 1'b1;
        end else begin
            done     <= 1'b0;
            arb_lost <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go && (command != CMD_IDLE)) begin
                        cmd_q          <= cmd_e'(command);
                        state          <= S_RUN;
                        busy           <= 1'b1;
                        pre            <= '0;
                        slot           <= 3'd0;
                        {scl_o, sda_o} <= slot_drive(cmd_e'(command), 3'd0, scl_o, sda_o);
                    end
                end
                S_RUN: begin
                    if (arb_hit) begin
                        // Another master owns SDA: back off completely
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                        arb_lost <= 1'b1;
                        scl_o    <= 1'b1;
                        sda_o    <= 1'b1;
                    end else if (!freeze) begin
                        if (pre == PRE_LAST) begin
                            pre <= '0;
                            if ((cmd_q == CMD_READ) && (slot == 3'd5)) begin
                                rx_bit <= sda_s;
                            end
                            if (slot == 3'd7) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                slot           <= slot + 3'd1;
                                {scl_o, sda_o} <= slot_drive(cmd_q, slot + 3'd1, scl_o, sda_o);
                            end
                        end else begin
                            pre <= pre + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_bit_engine.sv
// Directed testbench for i2c_master_bit_engine with SLOT_CYCLES=2 (16-clock symbols).
module tb_i2c_master_bit_engine;

    localparam int SC = 2;
    localparam logic [2:0] CMD_IDLE   = 3'b000;
    localparam logic [2:0] CMD_READ   = 3'b001;
    localparam logic [2:0] CMD_START  = 3'b010;
    localparam logic [2:0] CMD_STOP   = 3'b011;
    localparam logic [2:0] CMD_DATA_0 = 3'b100;
    localparam logic [2:0] CMD_DATA_1 = 3'b101;

`ifdef I2C_CLOCK_STRETCH_EN
    localparam int STRETCH_DONE = 26;
`else
    localparam int STRETCH_DONE = 16;
`endif

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       go      = 1'b0;
    logic [2:0] command = 3'b000;
    logic       busy, done, rx_bit, arb_lost, scl_o, sda_o, scl_i, sda_i;
    logic       sda_ext = 1'b1;
    logic       scl_ext = 1'b1;

    int checks = 0;
    int passed = 0;

    assign sda_i = sda_o & sda_ext;
    assign scl_i = scl_ext;

    always #5 clock = ~clock;

    i2c_master_bit_engine #(.SLOT_CYCLES(SC), .SYNC_STAGES(2)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .go       (go),
        .command  (command),
        .busy     (busy),
        .done     (done),
        .rx_bit   (rx_bit),
        .arb_lost (arb_lost),
        .scl_o    (scl_o),
        .sda_o    (sda_o),
        .scl_i    (scl_i),
        .sda_i    (sda_i)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Leaves the bench 1 time unit after the accept edge E0
    task automatic accept(input logic [2:0] cmd);
        @(negedge clock);
        go      = 1'b1;
        command = cmd;
        @(posedge clock);
        #1;
        go      = 1'b0;
        command = CMD_IDLE;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (scl_o !== 1'b1)    $display("FAIL reset_scl got %b want 1", scl_o);    else passed++;
        checks++; if (sda_o !== 1'b1)    $display("FAIL reset_sda got %b want 1", sda_o);    else passed++;
        checks++; if (busy !== 1'b0)     $display("FAIL reset_busy got %b want 0", busy);    else passed++;
        checks++; if (done !== 1'b0)     $display("FAIL reset_done got %b want 0", done);    else passed++;
        checks++; if (rx_bit !== 1'b0)   $display("FAIL reset_rx got %b want 0", rx_bit);    else passed++;
        checks++; if (arb_lost !== 1'b0) $display("FAIL reset_arb got %b want 0", arb_lost); else passed++;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_idle_ignored();
        @(negedge clock);
        go      = 1'b1;
        command = CMD_IDLE;
        step();
        step();
        checks++; if (busy !== 1'b0) $display("FAIL idle_go_busy got %b want 0", busy); else passed++;
        go = 1'b0;
    endtask

    task automatic test_start();
        int   dn;
        int   fall;
        logic scl_ok;
        accept(CMD_START);
        checks++; if (busy !== 1'b1) $display("FAIL start_busy got %b want 1", busy); else passed++;
        dn     = -1;
        fall   = -1;
        scl_ok = (scl_o === 1'b1);
        for (int n = 1; n <= 40; n++) begin
            step();
            if (scl_o !== 1'b1) scl_ok = 1'b0;
            if (fall < 0 && sda_o === 1'b0) fall = n;
            if (done === 1'b1) begin
                dn = n;
                break;
            end
        end
        checks++; if (fall != 12)     $display("FAIL start_sda_fall got %0d want 12", fall); else passed++;
        checks++; if (dn != 16)       $display("FAIL start_done got %0d want 16", dn);       else passed++;
        checks++; if (scl_ok !== 1'b1) $display("FAIL start_scl_high got %b want 1", scl_ok); else passed++;
    endtask

    task automatic test_back_to_back();
        int   d1;
        int   d2;
        logic arb_seen;
        logic scl_ok;
        logic sda8;
        logic sda_d0;
        accept(CMD_DATA_1);
        d1       = -1;
        d2       = -1;
        arb_seen = 1'b0;
        scl_ok   = (scl_o === 1'b0);
        sda8     = 1'bx;
        sda_d0   = 1'bx;
        for (int n = 1; n <= 80 && d2 < 0; n++) begin
            step();
            if (arb_lost === 1'b1) arb_seen = 1'b1;
            if (d1 < 0 && n < 16 && scl_o !== (n >= 8)) scl_ok = 1'b0;
            if (n == 4) begin
                go      = 1'b1;
                command = CMD_STOP;
            end
            if (n == 5) begin
                go      = 1'b0;
                command = CMD_IDLE;
            end
            if (n == 8) sda8 = sda_o;
            if (d1 >= 0 && n == d1 + 1) begin
                go      = 1'b0;
                command = CMD_IDLE;
            end
            if (d1 >= 0 && n == d1 + 3) sda_d0 = sda_o;
            if (done === 1'b1) begin
                if (d1 < 0) begin
                    d1      = n;
                    go      = 1'b1;
                    command = CMD_DATA_0;
                end else begin
                    d2 = n;
                end
            end
        end
        checks++; if (d1 != 16)          $display("FAIL b2b_done1 got %0d want 16", d1);          else passed++;
        checks++; if (d2 != 33)          $display("FAIL b2b_done2 got %0d want 33", d2);          else passed++;
        checks++; if (arb_seen !== 1'b0) $display("FAIL b2b_arb got %b want 0", arb_seen);       else passed++;
        checks++; if (scl_ok !== 1'b1)   $display("FAIL b2b_scl_pattern got %b want 1", scl_ok); else passed++;
        checks++; if (sda8 !== 1'b1)     $display("FAIL b2b_data1_sda got %b want 1", sda8);     else passed++;
        checks++; if (sda_d0 !== 1'b0)   $display("FAIL b2b_data0_sda got %b want 0", sda_d0);   else passed++;
    endtask

    task automatic test_read();
        int   dn;
        logic sda_ok;
        // First READ sees a released line
        accept(CMD_READ);
        dn = -1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (done === 1'b1) begin
                dn = n;
                break;
            end
        end
        checks++; if (dn != 16)        $display("FAIL read1_done got %0d want 16", dn); else passed++;
        checks++; if (rx_bit !== 1'b1) $display("FAIL read1_rx got %b want 1", rx_bit);  else passed++;
        // Second READ: slave pulls SDA low over slots 4-6
        accept(CMD_READ);
        dn     = -1;
        sda_ok = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (n == 7)  sda_ext = 1'b0;
            if (n == 14) sda_ext = 1'b1;
            if (n >= 2 && sda_o !== 1'b1) sda_ok = 1'b0;
            if (done === 1'b1) begin
                dn = n;
                break;
            end
        end
        sda_ext = 1'b1;
        checks++; if (dn != 16)        $display("FAIL read0_done got %0d want 16", dn);     else passed++;
        checks++; if (rx_bit !== 1'b0) $display("FAIL read0_rx got %b want 0", rx_bit);      else passed++;
        checks++; if (sda_ok !== 1'b1) $display("FAIL read_sda_released got %b want 1", sda_ok); else passed++;
    endtask

    task automatic test_arbitration();
        int   at;
        int   pulses;
        logic done_seen;
        logic busy_a;
        logic scl_a;
        logic sda_a;
        accept(CMD_DATA_1);
        at        = -1;
        pulses    = 0;
        done_seen = 1'b0;
        busy_a    = 1'bx;
        scl_a     = 1'bx;
        sda_a     = 1'bx;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (n == 8) sda_ext = 1'b0;
            if (done === 1'b1) done_seen = 1'b1;
            if (arb_lost === 1'b1) begin
                pulses++;
                if (at < 0) begin
                    at     = n;
                    busy_a = busy;
                    scl_a  = scl_o;
                    sda_a  = sda_o;
                end
            end
        end
        sda_ext = 1'b1;
        checks++; if (at != 11)           $display("FAIL arb_time got %0d want 11", at);         else passed++;
        checks++; if (pulses != 1)        $display("FAIL arb_pulse_len got %0d want 1", pulses); else passed++;
        checks++; if (busy_a !== 1'b0)    $display("FAIL arb_busy got %b want 0", busy_a);       else passed++;
        checks++; if (scl_a !== 1'b1)     $display("FAIL arb_scl got %b want 1", scl_a);         else passed++;
        checks++; if (sda_a !== 1'b1)     $display("FAIL arb_sda got %b want 1", sda_a);         else passed++;
        checks++; if (done_seen !== 1'b0) $display("FAIL arb_no_done got %b want 0", done_seen); else passed++;
    endtask

    task automatic test_stretch();
        int dn;
        accept(CMD_DATA_0);
        dn = -1;
        for (int n = 1; n <= 60; n++) begin
            step();
            if (n == 7)  scl_ext = 1'b0;
            if (n == 17) scl_ext = 1'b1;
            if (done === 1'b1) begin
                dn = n;
                break;
            end
        end
        scl_ext = 1'b1;
        checks++; if (dn != STRETCH_DONE) $display("FAIL stretch_done got %0d want %0d", dn, STRETCH_DONE); else passed++;
    endtask

    task automatic test_reset_mid();
        int   dn;
        logic scl8;
        logic sda10;
        logic sda12;
        accept(CMD_DATA_0);
        repeat (7) step();
        reset_n = 1'b0;
        #1;
        checks++; if (scl_o !== 1'b1) $display("FAIL rstmid_scl got %b want 1", scl_o); else passed++;
        checks++; if (sda_o !== 1'b1) $display("FAIL rstmid_sda got %b want 1", sda_o); else passed++;
        checks++; if (busy !== 1'b0)  $display("FAIL rstmid_busy got %b want 0", busy); else passed++;
        @(negedge clock);
        reset_n = 1'b1;
        accept(CMD_STOP);
        checks++; if (busy !== 1'b1) $display("FAIL stop_accept_busy got %b want 1", busy); else passed++;
        dn    = -1;
        scl8  = 1'bx;
        sda10 = 1'bx;
        sda12 = 1'bx;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (n == 8)  scl8  = scl_o;
            if (n == 10) sda10 = sda_o;
            if (n == 12) sda12 = sda_o;
            if (done === 1'b1) begin
                dn = n;
                break;
            end
        end
        checks++; if (dn != 16)       $display("FAIL stop_done got %0d want 16", dn);     else passed++;
        checks++; if (scl8 !== 1'b1)  $display("FAIL stop_scl_s4 got %b want 1", scl8);   else passed++;
        checks++; if (sda10 !== 1'b0) $display("FAIL stop_sda_s5 got %b want 0", sda10);  else passed++;
        checks++; if (sda12 !== 1'b1) $display("FAIL stop_sda_s6 got %b want 1", sda12);  else passed++;
    endtask

    initial begin
        test_reset();
        test_idle_ignored();
        test_start();
        test_back_to_back();
        test_read();
        test_arbitration();
        test_stretch();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
